btb_update_buffer: RTL and testbench



---
 rtl/btb_pkg.sv | 20 ++
 rtl/btb_upd_fifo.sv | 71 +++++++
 rtl/btb_update_buffer.sv | 110 +++++++++++
 tb/tb_btb_update_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared BTB types and helpers, used by the update buffer and by the BTB itself.
// PCs and targets are word addresses, bits [31:2] of the byte address.
package btb_pkg;

   typedef struct packed {
      logic [31:2] tag;
      logic [31:2] target;
      logic        entry_valid;
   } btb_update_t;

   // Direct-mapped set index: the low log2(entries) bits of the word PC.
   function automatic logic [31:2] idx_of(input logic [31:2] pc, input int entries);
      return pc & 30'(entries - 1);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// DEPTH-entry circular queue of BTB updates with in-place rewrite of the youngest slot.
// Head is held in its own register: data appears one cycle after push; caller gates push on count.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_vld,
   input  logic                  merge_vld,
   input  btb_update_t           wr_dat,
   input  logic                  pop_vld,
   output btb_update_t           head_dat,
   output logic [29:0]           tail_tag,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   btb_update_t      mem_q [DEPTH];
   btb_update_t      head_dat_q, head_dat_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W-1:0] youngest, wr_slot;
   logic [PTR_W:0]   count_q, count_d;
   logic             wr_en;

   always_comb begin
      youngest = tail_q - 1'b1;
      wr_en    = push_vld || merge_vld;
      wr_slot  = merge_vld ? youngest : tail_q;
      head_d   = pop_vld  ? head_q + 1'b1 : head_q;
      tail_d   = push_vld ? tail_q + 1'b1 : tail_q;
      count_d  = count_q;
      if (push_vld && !pop_vld) begin
         count_d = count_q + 1'b1;
      end else if (!push_vld && pop_vld) begin
         count_d = count_q - 1'b1;
      end
      // Next head comes from storage unless this cycle's write lands in that slot.
      head_dat_d = head_dat_q;
      if (count_d != '0) begin
         head_dat_d = (wr_en && (wr_slot == head_d)) ? wr_dat : mem_q[head_d];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_slot] <= wr_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         head_dat_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         head_dat_q <= head_dat_d;
      end
   end

   assign head_dat = head_dat_q;
   assign tail_tag = mem_q[youngest].tag;
   assign count    = count_q;

endmodule

// File: rtl/btb_update_buffer.sv
// Filters, coalesces and queues resolved branches into BTB writes; one cycle accept-to-wr_valid.
// Stalls res_ready only when full; optional counters under BTB_UPD_STATS_EN.
module btb_update_buffer
   import btb_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int BTB_ENTRIES = 1024
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           res_valid,
   output logic                           res_ready,
   input  logic [29:0]                    res_pc,
   input  logic [29:0]                    res_target,
   input  logic                           res_taken,
   input  logic                           res_pred_hit,
   input  logic [29:0]                    res_pred_target,
   output logic                           wr_valid,
   input  logic                           wr_ready,
   output logic [$clog2(BTB_ENTRIES)-1:0] wr_index,
   output logic [29:0]                    wr_tag,
   output logic [29:0]                    wr_target,
   output logic                           wr_entry_valid,
   output logic [$clog2(DEPTH):0]         occupancy
`ifdef BTB_UPD_STATS_EN
   ,
   output logic [31:0]                    stat_installs,
   output logic [31:0]                    stat_invalidates,
   output logic [31:0]                    stat_dropped,
   output logic [31:0]                    stat_merged
`endif
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [CNT_W-1:0] count;
   btb_update_t      head_dat, upd;
   logic [29:0]      tail_tag;
   logic             accept, install, invalidate, keep, pop, merge, push;

   always_comb begin
      accept     = res_valid && res_ready;
      install    = res_taken && (!res_pred_hit || (res_pred_target != res_target));
      invalidate = !res_taken && res_pred_hit;
      keep       = install || invalidate;
      pop        = wr_valid && wr_ready;
      // A lone entry leaving this cycle can no longer absorb a merge.
      merge      = accept && keep && (count != '0) && (tail_tag == res_pc)
                   && !((count == CNT_W'(1)) && pop);
      push       = accept && keep && !merge;
      upd.tag         = res_pc;
      upd.target      = install ? res_target : '0;
      upd.entry_valid = install;
   end

   btb_upd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_vld  (push),
      .merge_vld (merge),
      .wr_dat    (upd),
      .pop_vld   (pop),
      .head_dat  (head_dat),
      .tail_tag  (tail_tag),
      .count     (count)
   );

   assign res_ready      = (count != CNT_W'(DEPTH));
   assign wr_valid       = (count != '0);
   assign wr_index       = IDX_W'(idx_of(head_dat.tag, BTB_ENTRIES));
   assign wr_tag         = head_dat.tag;
   assign wr_target      = head_dat.target;
   assign wr_entry_valid = head_dat.entry_valid;
   assign occupancy      = count;

`ifdef BTB_UPD_STATS_EN
   logic [31:0] installs_q, installs_d, invalidates_q, invalidates_d;
   logic [31:0] dropped_q, dropped_d, merged_q, merged_d;

   always_comb begin
      installs_d    = sat_inc(installs_q, pop && head_dat.entry_valid);
      invalidates_d = sat_inc(invalidates_q, pop && !head_dat.entry_valid);
      dropped_d     = sat_inc(dropped_q, accept && !keep);
      merged_d      = sat_inc(merged_q, merge);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         installs_q    <= '0;
         invalidates_q <= '0;
         dropped_q     <= '0;
         merged_q      <= '0;
      end else begin
         installs_q    <= installs_d;
         invalidates_q <= invalidates_d;
         dropped_q     <= dropped_d;
         merged_q      <= merged_d;
      end
   end

   assign stat_installs    = installs_q;
   assign stat_invalidates = invalidates_q;
   assign stat_dropped     = dropped_q;
   assign stat_merged      = merged_q;
`endif

endmodule

// File: tb/tb_btb_update_buffer.sv
// Directed bench for btb_update_buffer: expected BTB writes are queued at issue and
// matched in order by a monitor on every wr_valid && wr_ready.
module tb_btb_update_buffer;

   localparam int DEPTH       = 4;
   localparam int BTB_ENTRIES = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic [29:0] res_pc = '0;
   logic [29:0] res_target = '0;
   logic        res_taken = 1'b0;
   logic        res_pred_hit = 1'b0;
   logic [29:0] res_pred_target = '0;
   logic        wr_valid;
   logic        wr_ready = 1'b0;
   logic [9:0]  wr_index;
   logic [29:0] wr_tag;
   logic [29:0] wr_target;
   logic        wr_entry_valid;
   logic [2:0]  occupancy;

   typedef struct packed {
      logic [29:0] tag;
      logic [29:0] tgt;
      logic        ev;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   n_writes = 0;
   int   w0;

   always #5 clk = ~clk;

   btb_update_buffer #(
      .DEPTH       (DEPTH),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_pc          (res_pc),
      .res_target      (res_target),
      .res_taken       (res_taken),
      .res_pred_hit    (res_pred_hit),
      .res_pred_target (res_pred_target),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .wr_index        (wr_index),
      .wr_tag          (wr_tag),
      .wr_target       (wr_target),
      .wr_entry_valid  (wr_entry_valid),
      .occupancy       (occupancy)
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [29:0] tag, input logic [29:0] tgt, input logic ev);
      exp_t x;
      x = {tag, tgt, ev};
      sb.push_back(x);
   endtask

   task automatic send(input logic [29:0] pc, input logic [29:0] tgt, input logic taken,
                       input logic hit, input logic [29:0] ptgt);
      int n;
      n = 0;
      res_valid       = 1'b1;
      res_pc          = pc;
      res_target      = tgt;
      res_taken       = taken;
      res_pred_hit    = hit;
      res_pred_target = ptgt;
      while (!res_ready && n < 50) begin
         tick();
         n++;
      end
      if (!res_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout pc %0h got res_ready 0 exp 1", pc);
      end else begin
         tick();
      end
      res_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (wr_valid && n < 40) begin
         tick();
         n++;
      end
      check("drain_wr_valid", 96'(wr_valid), 96'(0));
      check("drain_sb_empty", 96'(sb.size()), 96'(0));
   endtask

   // Write monitor: a transfer happens at the next posedge when both are high here.
   always @(negedge clk) begin
      if (rst_n && wr_valid && wr_ready) begin
         n_writes++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write got tag %0h target %0h ev %0b exp none",
                     wr_tag, wr_target, wr_entry_valid);
         end else begin
            mon_e = sb.pop_front();
            check("write", 96'({wr_index, wr_tag, wr_target, wr_entry_valid}),
                  96'({mon_e.tag[9:0], mon_e.tag, mon_e.tgt, mon_e.ev}));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #2;
      check("rst_wr_valid", 96'(wr_valid), 96'(0));
      check("rst_res_ready", 96'(res_ready), 96'(1));
      check("rst_occ", 96'(occupancy), 96'(0));
      check("rst_fields", 96'({wr_index, wr_tag, wr_target, wr_entry_valid}), 96'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // First install, observed while stalled
      wr_ready = 1'b0;
      expect_wr(30'h100, 30'h200, 1'b1);
      send(30'h100, 30'h200, 1'b1, 1'b0, 30'h0);
      check("t1_wr_valid", 96'(wr_valid), 96'(1));
      check("t1_occ", 96'(occupancy), 96'(1));
      check("t1_fields", 96'({wr_index, wr_tag, wr_target, wr_entry_valid}),
            96'({10'h100, 30'h100, 30'h200, 1'b1}));
      wr_ready = 1'b1;
      wait_drain();

      // Correctly predicted taken branch, and not-taken miss: both dropped
      send(30'h180, 30'h300, 1'b1, 1'b1, 30'h300);
      check("drop_pred_wr_valid", 96'(wr_valid), 96'(0));
      send(30'h184, 30'h333, 1'b0, 1'b0, 30'h0);
      tick();
      check("drop_nt_wr_valid", 96'(wr_valid), 96'(0));
      check("drop_occ", 96'(occupancy), 96'(0));

      // Not-taken hit -> invalidate with zero target
      wr_ready = 1'b0;
      expect_wr(30'h104, 30'h0, 1'b0);
      send(30'h104, 30'h777, 1'b0, 1'b1, 30'h55);
      check("inv_fields", 96'({wr_target, wr_entry_valid}), 96'({30'h0, 1'b0}));
      wr_ready = 1'b1;
      wait_drain();

      // Hit with wrong target -> install
      expect_wr(30'h108, 30'h400, 1'b1);
      send(30'h108, 30'h400, 1'b1, 1'b1, 30'h3FC);
      wait_drain();

      // Fill to DEPTH, hold a fifth, then drain in order
      wr_ready = 1'b0;
      w0 = n_writes;
      for (int i = 0; i < 4; i++) begin
         expect_wr(30'h200 + 30'(4 * i), 30'h1000 + 30'(i), 1'b1);
         send(30'h200 + 30'(4 * i), 30'h1000 + 30'(i), 1'b1, 1'b0, 30'h0);
      end
      check("full_occ", 96'(occupancy), 96'(4));
      check("full_res_ready", 96'(res_ready), 96'(0));
      expect_wr(30'h210, 30'h1010, 1'b1);
      fork
         send(30'h210, 30'h1010, 1'b1, 1'b0, 30'h0);
         begin
            repeat (3) tick();
            check("full_hold_occ", 96'(occupancy), 96'(4));
            check("full_hold_rdy", 96'(res_ready), 96'(0));
            check("full_head_stable", 96'(wr_tag), 96'(30'h200));
            wr_ready = 1'b1;
         end
      join
      wait_drain();
      check("full_write_count", 96'(n_writes - w0), 96'(5));

      // Coalesce into the (stalled) head
      wr_ready = 1'b0;
      w0 = n_writes;
      expect_wr(30'h140, 30'h600, 1'b1);
      send(30'h140, 30'h500, 1'b1, 1'b0, 30'h0);
      send(30'h140, 30'h600, 1'b1, 1'b0, 30'h0);
      check("coal_occ", 96'(occupancy), 96'(1));
      check("coal_target", 96'(wr_target), 96'(30'h600));
      wr_ready = 1'b1;
      wait_drain();
      check("coal_write_count", 96'(n_writes - w0), 96'(1));

      // Coalesce into a non-head youngest; older same-PC entry is not merged
      wr_ready = 1'b0;
      expect_wr(30'h300, 30'h10, 1'b1);
      expect_wr(30'h304, 30'h30, 1'b1);
      expect_wr(30'h300, 30'h40, 1'b1);
      send(30'h300, 30'h10, 1'b1, 1'b0, 30'h0);
      send(30'h304, 30'h20, 1'b1, 1'b0, 30'h0);
      send(30'h304, 30'h30, 1'b1, 1'b0, 30'h0);
      check("coal2_occ", 96'(occupancy), 96'(2));
      send(30'h300, 30'h40, 1'b1, 1'b0, 30'h0);
      check("coal3_occ", 96'(occupancy), 96'(3));
      wr_ready = 1'b1;
      wait_drain();

      // Same PC arrives while its single entry is being written: no merge
      w0 = n_writes;
      expect_wr(30'h400, 30'h50, 1'b1);
      expect_wr(30'h400, 30'h60, 1'b1);
      send(30'h400, 30'h50, 1'b1, 1'b0, 30'h0);
      send(30'h400, 30'h60, 1'b1, 1'b0, 30'h0);
      wait_drain();
      check("xfer_write_count", 96'(n_writes - w0), 96'(2));

      // Reset with three queued entries discards them
      wr_ready = 1'b0;
      send(30'h500, 30'h1, 1'b1, 1'b0, 30'h0);
      send(30'h504, 30'h2, 1'b1, 1'b0, 30'h0);
      send(30'h508, 30'h3, 1'b1, 1'b0, 30'h0);
      check("prerst_occ", 96'(occupancy), 96'(3));
      rst_n = 1'b0;
      #2;
      check("inrst_wr_valid", 96'(wr_valid), 96'(0));
      check("inrst_occ", 96'(occupancy), 96'(0));
      tick();
      tick();
      rst_n = 1'b1;
      wr_ready = 1'b1;
      w0 = n_writes;
      repeat (5) tick();
      check("postrst_wr_valid", 96'(wr_valid), 96'(0));
      check("postrst_occ", 96'(occupancy), 96'(0));
      check("postrst_res_ready", 96'(res_ready), 96'(1));
      check("postrst_writes", 96'(n_writes - w0), 96'(0));

      // Still functional after reset
      expect_wr(30'h600, 30'h70, 1'b1);
      send(30'h600, 30'h70, 1'b1, 1'b0, 30'h0);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
